// File: rtl/matrix_tile_file.sv
// -----------------------------------------------------------------------------
// matrix_tile_file
//   Matrix register file for the matrix extension: TILES tiles, each holding
//   ROWS rows of DATA_W bits. Supports single-row writes, whole-tile (MOPA)
//   writes and a one-cycle tile clear. A valid/ready drain engine streams one
//   tile, row by row, towards the LSU matrix-store port.
//
// Ports
//   clk, rst                 clock (posedge) / asynchronous active-low reset
//   r_tile_index,
//   r_matrix_index           combinational single-row read -> r_matrix_o
//   acc_tile_index           tile presented whole on M_out (row r at r*DATA_W)
//   w_tile_index, w_matrix_index, w_matrix_data, w_matrix_en
//                            single-row write port
//   mopa_tile_index, w_matrix_data_mopa, w_matrix_en_mopa
//                            whole-tile write port (same packing as M_out)
//   zero_tile_index, zero_en tile clear
//   drain_start, drain_tile_index
//                            start streaming a tile (ignored while busy)
//   drain_valid, drain_ready, drain_row, drain_data
//                            drain beat handshake
//   drain_busy, drain_done   engine activity / one-cycle completion pulse
//   wr_conflict              one-cycle pulse: a write hit the tile being drained
// -----------------------------------------------------------------------------
module matrix_tile_file #(
    parameter  int DATA_W = 32,
    parameter  int ROWS   = 4,
    parameter  int TILES  = 2,
    localparam int IDX_W  = $clog2(ROWS),
    localparam int TILE_W = $clog2(TILES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TILE_W-1:0]        r_tile_index,
    input  logic [IDX_W-1:0]         r_matrix_index,
    output logic [DATA_W-1:0]        r_matrix_o,
    input  logic [TILE_W-1:0]        acc_tile_index,
    output logic [ROWS*DATA_W-1:0]   M_out,
    input  logic [TILE_W-1:0]        w_tile_index,
    input  logic [IDX_W-1:0]         w_matrix_index,
    input  logic [DATA_W-1:0]        w_matrix_data,
    input  logic                     w_matrix_en,
    input  logic [TILE_W-1:0]        mopa_tile_index,
    input  logic [ROWS*DATA_W-1:0]   w_matrix_data_mopa,
    input  logic                     w_matrix_en_mopa,
    input  logic [TILE_W-1:0]        zero_tile_index,
    input  logic                     zero_en,
    input  logic                     drain_start,
    input  logic [TILE_W-1:0]        drain_tile_index,
    output logic                     drain_valid,
    input  logic                     drain_ready,
    output logic [IDX_W-1:0]         drain_row,
    output logic [DATA_W-1:0]        drain_data,
    output logic                     drain_busy,
    output logic                     drain_done,
    output logic                     wr_conflict
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } drain_state_t;

    logic [DATA_W-1:0] r_mem [TILES][ROWS];
    drain_state_t      r_state;
    logic [TILE_W-1:0] r_drain_tile;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_wr_conflict;

    logic [TILES-1:0]  w_zero_hit;
    logic [TILES-1:0]  w_mopa_hit;
    logic [TILES-1:0]  w_row_hit;
    logic [TILES-1:0]  w_locked;
    logic              w_dropped;

    // Per-tile decode of the three write ports and of the drain lock.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_zero_hit = '0;
        w_mopa_hit = '0;
        w_row_hit  = '0;
        w_locked   = '0;
        for (int t = 0; t < TILES; t++) begin
            w_zero_hit[t] = zero_en          && (zero_tile_index == TILE_W'(t));
            w_mopa_hit[t] = w_matrix_en_mopa && (mopa_tile_index == TILE_W'(t));
            w_row_hit[t]  = w_matrix_en      && (w_tile_index    == TILE_W'(t));
            // The lock covers the DONE cycle too; it opens once the FSM is back in IDLE.
            w_locked[t]   = r_busy && (r_drain_tile == TILE_W'(t));
        end
    end

    // Any write of any kind aimed at the locked tile is reported, whatever its priority.
    assign w_dropped = |(w_locked & (w_zero_hit | w_mopa_hit | w_row_hit));

    // Tile storage. Priority within one tile: clear > whole-tile > single row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the storage is reset on purpose: every row must read 0 after reset,
            // so this array cannot be mapped to a RAM macro without a clear sequence.
            for (int t = 0; t < TILES; t++) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_mem[t][r] <= '0;
                end
            end
        end else begin
            for (int t = 0; t < TILES; t++) begin
                if (!w_locked[t]) begin
                    if (w_zero_hit[t]) begin
                        for (int r = 0; r < ROWS; r++) begin
                            r_mem[t][r] <= '0;
                        end
                    end else if (w_mopa_hit[t]) begin
                        for (int r = 0; r < ROWS; r++) begin
                            r_mem[t][r] <= w_matrix_data_mopa[r*DATA_W +: DATA_W];
                        end
                    end else if (w_row_hit[t]) begin
                        r_mem[t][w_matrix_index] <= w_matrix_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_conflict <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            r_wr_conflict <= w_dropped;
        end
    end

    // Drain engine with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_drain_tile <= '0;
            r_cnt        <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (drain_start) begin
                        r_state      <= S_STREAM;
                        r_drain_tile <= drain_tile_index;
                        r_cnt        <= '0;
                        r_valid      <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (drain_ready) begin
                        // Counter wraps to 0 after the last row since ROWS is a power of 2.
                        r_cnt <= r_cnt + IDX_W'(1);
                        if (r_cnt == IDX_W'(ROWS - 1)) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Whole-tile read view.
    always_comb begin
        M_out = '0;
        for (int r = 0; r < ROWS; r++) begin
            M_out[r*DATA_W +: DATA_W] = r_mem[acc_tile_index][r];
        end
    end

    assign r_matrix_o  = r_mem[r_tile_index][r_matrix_index];
    // The drained tile cannot change while streaming, so a direct read is stable.
    assign drain_data  = r_valid ? r_mem[r_drain_tile][r_cnt] : '0;
    assign drain_valid = r_valid;
    assign drain_row   = r_cnt;
    assign drain_busy  = r_busy;
    assign drain_done  = r_done;
    assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_matrix_tile_file.sv
// -----------------------------------------------------------------------------
// tb_matrix_tile_file
//   Self-checking bench for matrix_tile_file. A behavioural model holds the
//   tile contents as a plain array and applies the write rules each edge;
//   directed scenarios use hand-written constants, random scenarios use the model.
// -----------------------------------------------------------------------------
module tb_matrix_tile_file;

    localparam int DATA_W = 32;
    localparam int ROWS   = 4;
    localparam int TILES  = 2;
    localparam int IDX_W  = 2;
    localparam int TILE_W = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [TILE_W-1:0]      r_tile_index;
    logic [IDX_W-1:0]       r_matrix_index;
    logic [DATA_W-1:0]      r_matrix_o;
    logic [TILE_W-1:0]      acc_tile_index;
    logic [ROWS*DATA_W-1:0] M_out;
    logic [TILE_W-1:0]      w_tile_index;
    logic [IDX_W-1:0]       w_matrix_index;
    logic [DATA_W-1:0]      w_matrix_data;
    logic                   w_matrix_en;
    logic [TILE_W-1:0]      mopa_tile_index;
    logic [ROWS*DATA_W-1:0] w_matrix_data_mopa;
    logic                   w_matrix_en_mopa;
    logic [TILE_W-1:0]      zero_tile_index;
    logic                   zero_en;
    logic                   drain_start;
    logic [TILE_W-1:0]      drain_tile_index;
    logic                   drain_valid;
    logic                   drain_ready;
    logic [IDX_W-1:0]       drain_row;
    logic [DATA_W-1:0]      drain_data;
    logic                   drain_busy;
    logic                   drain_done;
    logic                   wr_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [DATA_W-1:0] model [TILES][ROWS];
    bit                exp_conflict;
    bit                m_lock;
    logic [TILE_W-1:0] m_lock_tile;

    always #10 clk = ~clk;

    matrix_tile_file #(.DATA_W(DATA_W), .ROWS(ROWS), .TILES(TILES)) dut (
        .clk                (clk),
        .rst                (rst),
        .r_tile_index       (r_tile_index),
        .r_matrix_index     (r_matrix_index),
        .r_matrix_o         (r_matrix_o),
        .acc_tile_index     (acc_tile_index),
        .M_out              (M_out),
        .w_tile_index       (w_tile_index),
        .w_matrix_index     (w_matrix_index),
        .w_matrix_data      (w_matrix_data),
        .w_matrix_en        (w_matrix_en),
        .mopa_tile_index    (mopa_tile_index),
        .w_matrix_data_mopa (w_matrix_data_mopa),
        .w_matrix_en_mopa   (w_matrix_en_mopa),
        .zero_tile_index    (zero_tile_index),
        .zero_en            (zero_en),
        .drain_start        (drain_start),
        .drain_tile_index   (drain_tile_index),
        .drain_valid        (drain_valid),
        .drain_ready        (drain_ready),
        .drain_row          (drain_row),
        .drain_data         (drain_data),
        .drain_busy         (drain_busy),
        .drain_done         (drain_done),
        .wr_conflict        (wr_conflict)
    );

    task automatic idle_inputs();
        w_matrix_en      = 1'b0;
        w_matrix_en_mopa = 1'b0;
        zero_en          = 1'b0;
        drain_start      = 1'b0;
        drain_ready      = 1'b0;
    endtask

    task automatic model_clear();
        for (int t = 0; t < TILES; t++)
            for (int r = 0; r < ROWS; r++)
                model[t][r] = '0;
        exp_conflict = 0;
    endtask

    // Advance one clock; the model applies the write rules to the pre-edge inputs.
    task automatic tick();
        logic [DATA_W-1:0] nxt [TILES][ROWS];
        bit conf;
        conf = 0;
        for (int t = 0; t < TILES; t++)
            for (int r = 0; r < ROWS; r++)
                nxt[t][r] = model[t][r];
        if (rst) begin
            for (int t = 0; t < TILES; t++) begin
                bit hz, hm, hw;
                hz = zero_en          && (int'(zero_tile_index) == t);
                hm = w_matrix_en_mopa && (int'(mopa_tile_index) == t);
                hw = w_matrix_en      && (int'(w_tile_index) == t);
                if (m_lock && int'(m_lock_tile) == t) begin
                    conf = conf | hz | hm | hw;
                end else if (hz) begin
                    for (int r = 0; r < ROWS; r++) nxt[t][r] = '0;
                end else if (hm) begin
                    for (int r = 0; r < ROWS; r++) nxt[t][r] = w_matrix_data_mopa[r*DATA_W +: DATA_W];
                end else if (hw) begin
                    nxt[t][w_matrix_index] = w_matrix_data;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int t = 0; t < TILES; t++)
            for (int r = 0; r < ROWS; r++)
                model[t][r] = nxt[t][r];
        exp_conflict = conf;
    endtask

    task automatic rand_writes();
        w_matrix_en        = ($urandom_range(0, 2) == 0);
        w_tile_index       = TILE_W'($urandom_range(0, TILES - 1));
        w_matrix_index     = IDX_W'($urandom_range(0, ROWS - 1));
        w_matrix_data      = $urandom;
        w_matrix_en_mopa   = ($urandom_range(0, 3) == 0);
        mopa_tile_index    = TILE_W'($urandom_range(0, TILES - 1));
        w_matrix_data_mopa = {$urandom, $urandom, $urandom, $urandom};
        zero_en            = ($urandom_range(0, 5) == 0);
        zero_tile_index    = TILE_W'($urandom_range(0, TILES - 1));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_lock = 0;
        model_clear();
        w_matrix_en = 1'b1; w_tile_index = 1; w_matrix_index = 2; w_matrix_data = 32'hFFFF_FFFF;
        w_matrix_en_mopa = 1'b1; mopa_tile_index = 0; w_matrix_data_mopa = {4{32'h1234_5678}};
        zero_en = 1'b0; zero_tile_index = 0;
        drain_start = 1'b1; drain_tile_index = 0; drain_ready = 1'b1;
        r_tile_index = 0; r_matrix_index = 0; acc_tile_index = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int t = 0; t < TILES; t++) begin
            acc_tile_index = TILE_W'(t);
            #1;
            n_checks++;
            if (M_out !== '0) begin
                n_fail++;
                $display("FAIL reset_tile%0d: got %h expected 0", t, M_out);
            end
        end
        n_checks++;
        if ({drain_valid, drain_busy, drain_done, wr_conflict} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got v/b/d/c=%b expected 0000",
                     {drain_valid, drain_busy, drain_done, wr_conflict});
        end
        n_checks++;
        if (drain_row !== '0 || drain_data !== '0) begin
            n_fail++;
            $display("FAIL reset_drain_bus: got row=%0d data=%h expected 0/0", drain_row, drain_data);
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        n_checks++;
        if (drain_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b expected 0", drain_busy);
        end
    endtask

    task automatic test_row_write();
        w_matrix_en = 1'b1; w_tile_index = 1; w_matrix_index = 2; w_matrix_data = 32'hDEAD_BEEF;
        r_tile_index = 1; r_matrix_index = 2;
        #1;
        n_checks++;
        if (r_matrix_o !== 32'h0) begin
            n_fail++;
            $display("FAIL row_write_early: got %h expected 00000000", r_matrix_o);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (r_matrix_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL row_write_t1r2: got %h expected deadbeef", r_matrix_o);
        end
        r_tile_index = 0;
        #1;
        n_checks++;
        if (r_matrix_o !== 32'h0) begin
            n_fail++;
            $display("FAIL row_write_t0r2: got %h expected 00000000", r_matrix_o);
        end
    endtask

    task automatic test_priority();
        w_matrix_en_mopa = 1'b1; mopa_tile_index = 0;
        w_matrix_data_mopa = {32'd4, 32'd3, 32'd2, 32'd1};
        w_matrix_en = 1'b1; w_tile_index = 0; w_matrix_index = 0; w_matrix_data = 32'hFF;
        zero_en = 1'b1; zero_tile_index = 1;
        tick();
        idle_inputs();
        acc_tile_index = 0;
        #1;
        n_checks++;
        if (M_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            n_fail++;
            $display("FAIL prio_mopa_over_row: got %h expected 4/3/2/1", M_out);
        end
        acc_tile_index = 1;
        #1;
        n_checks++;
        if (M_out !== '0) begin
            n_fail++;
            $display("FAIL prio_zero_t1: got %h expected 0", M_out);
        end
        w_matrix_en = 1'b1; w_tile_index = 1; w_matrix_index = 1; w_matrix_data = 32'h77;
        tick();
        w_matrix_en_mopa = 1'b1; mopa_tile_index = 1; w_matrix_data_mopa = {4{32'h5555_5555}};
        zero_en = 1'b1; zero_tile_index = 1;
        w_matrix_en = 1'b1; w_tile_index = 1; w_matrix_index = 3; w_matrix_data = 32'h99;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (M_out !== '0) begin
            n_fail++;
            $display("FAIL prio_zero_over_mopa: got %h expected 0", M_out);
        end
        w_matrix_en = 1'b1; w_tile_index = 0; w_matrix_index = 3; w_matrix_data = 32'h33;
        w_matrix_en_mopa = 1'b1; mopa_tile_index = 1; w_matrix_data_mopa = {32'h8, 32'h7, 32'h6, 32'h5};
        tick();
        idle_inputs();
        acc_tile_index = 0;
        #1;
        n_checks++;
        if (M_out !== {32'h33, 32'd3, 32'd2, 32'd1}) begin
            n_fail++;
            $display("FAIL multi_tile_t0: got %h expected 33/3/2/1", M_out);
        end
        acc_tile_index = 1;
        #1;
        n_checks++;
        if (M_out !== {32'h8, 32'h7, 32'h6, 32'h5}) begin
            n_fail++;
            $display("FAIL multi_tile_t1: got %h expected 8/7/6/5", M_out);
        end
    endtask

    task automatic test_drain();
        int          exp_row [6] = '{0, 1, 1, 1, 2, 3};
        bit          pat [6]     = '{1, 0, 0, 1, 1, 1};
        logic [31:0] exp_val [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
        w_matrix_en_mopa = 1'b1; mopa_tile_index = 0;
        w_matrix_data_mopa = {32'hD, 32'hC, 32'hB, 32'h0};
        tick();
        idle_inputs();
        // Row 0 is written in the same cycle the drain starts; the first beat must carry it.
        w_matrix_en = 1'b1; w_tile_index = 0; w_matrix_index = 0; w_matrix_data = 32'hA;
        drain_start = 1'b1; drain_tile_index = 0;
        tick();
        idle_inputs();
        m_lock = 1; m_lock_tile = 0;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if ({drain_valid, drain_busy, drain_done, drain_row, drain_data} !==
                {1'b1, 1'b1, 1'b0, IDX_W'(exp_row[c]), exp_val[exp_row[c]]}) begin
                n_fail++;
                $display("FAIL drain_beat_c%0d: got v=%b b=%b d=%b row=%0d data=%h expected 1/1/0 row=%0d data=%h",
                         c, drain_valid, drain_busy, drain_done, drain_row, drain_data,
                         exp_row[c], exp_val[exp_row[c]]);
            end
            // A start request mid-stream must be ignored.
            drain_start = (c == 2);
            drain_tile_index = 1;
            drain_ready = pat[c];
            tick();
            drain_start = 1'b0;
        end
        drain_ready = 1'b0;
        n_checks++;
        if ({drain_done, drain_valid, drain_busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL drain_done_cycle: got d/v/b=%b expected 101", {drain_done, drain_valid, drain_busy});
        end
        tick();
        m_lock = 0;
        n_checks++;
        if ({drain_done, drain_valid, drain_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL drain_after_done: got d/v/b=%b expected 000", {drain_done, drain_valid, drain_busy});
        end
    endtask

    task automatic test_lock();
        logic [DATA_W-1:0] snap [ROWS];
        logic [ROWS*DATA_W-1:0] snap_p;
        w_matrix_en_mopa = 1'b1; mopa_tile_index = 0;
        w_matrix_data_mopa = {$urandom, $urandom, $urandom, $urandom};
        tick();
        idle_inputs();
        for (int r = 0; r < ROWS; r++) begin
            snap[r] = w_matrix_data_mopa[r*DATA_W +: DATA_W];
            snap_p[r*DATA_W +: DATA_W] = snap[r];
        end
        drain_start = 1'b1; drain_tile_index = 0;
        tick();
        idle_inputs();
        m_lock = 1; m_lock_tile = 0;
        w_matrix_en = 1'b1; w_tile_index = 0; w_matrix_index = 0; w_matrix_data = 32'h55;
        tick();
        idle_inputs();
        n_checks++;
        if (wr_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_conflict_row: got %b expected 1", wr_conflict);
        end
        n_checks++;
        if (drain_data !== snap[0]) begin
            n_fail++;
            $display("FAIL lock_t0r0_kept: got %h expected %h", drain_data, snap[0]);
        end
        w_matrix_en = 1'b1; w_tile_index = 1; w_matrix_index = 0; w_matrix_data = 32'h66;
        tick();
        idle_inputs();
        r_tile_index = 1; r_matrix_index = 0;
        #1;
        n_checks++;
        if (wr_conflict !== 1'b0 || r_matrix_o !== 32'h66) begin
            n_fail++;
            $display("FAIL lock_other_tile: got conflict=%b t1r0=%h expected 0/00000066", wr_conflict, r_matrix_o);
        end
        zero_en = 1'b1; zero_tile_index = 0;
        w_matrix_en_mopa = 1'b1; mopa_tile_index = 0; w_matrix_data_mopa = '1;
        tick();
        idle_inputs();
        acc_tile_index = 0;
        #1;
        n_checks++;
        if (wr_conflict !== 1'b1 || M_out !== snap_p) begin
            n_fail++;
            $display("FAIL lock_zero_mopa: got conflict=%b tile=%h expected 1/%h", wr_conflict, M_out, snap_p);
        end
        drain_ready = 1'b1;
        for (int k = 0; k < 10 && !drain_done; k++) tick();
        drain_ready = 1'b0;
        n_checks++;
        if (drain_done !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_drain_timeout: got done=%b expected 1", drain_done);
        end
        tick();
        m_lock = 0;
        w_matrix_en = 1'b1; w_tile_index = 0; w_matrix_index = 0; w_matrix_data = 32'h55;
        tick();
        idle_inputs();
        r_tile_index = 0; r_matrix_index = 0;
        #1;
        n_checks++;
        if (r_matrix_o !== 32'h55 || wr_conflict !== 1'b0 || drain_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_retry: got t0r0=%h conflict=%b busy=%b expected 00000055/0/0",
                     r_matrix_o, wr_conflict, drain_busy);
        end
    endtask

    task automatic test_reset_mid_drain();
        int idx;
        w_matrix_en_mopa = 1'b1; mopa_tile_index = 1;
        w_matrix_data_mopa = {$urandom, $urandom, $urandom, $urandom};
        tick();
        idle_inputs();
        drain_start = 1'b1; drain_tile_index = 1;
        tick();
        drain_start = 1'b0;
        m_lock = 1; m_lock_tile = 1;
        drain_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({drain_valid, drain_busy, drain_done} !== 3'b000 || drain_row !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_drain: got v/b/d=%b row=%0d expected 000 row=0",
                     {drain_valid, drain_busy, drain_done}, drain_row);
        end
        model_clear();
        m_lock = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drain_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (drain_done !== 1'b0 || drain_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_done_%0d: got done=%b busy=%b expected 0/0", k, drain_done, drain_busy);
            end
        end
        w_matrix_en_mopa = 1'b1; mopa_tile_index = 1;
        w_matrix_data_mopa = {$urandom, $urandom, $urandom, $urandom};
        tick();
        idle_inputs();
        drain_start = 1'b1; drain_tile_index = 1;
        tick();
        drain_start = 1'b0;
        m_lock = 1; m_lock_tile = 1;
        drain_ready = 1'b1;
        idx = 0;
        for (int k = 0; k < ROWS; k++) begin
            n_checks++;
            if (drain_valid !== 1'b1 || drain_row !== IDX_W'(idx) || drain_data !== model[1][idx]) begin
                n_fail++;
                $display("FAIL rst_redrain_beat%0d: got v=%b row=%0d data=%h expected 1 row=%0d data=%h",
                         idx, drain_valid, drain_row, drain_data, idx, model[1][idx]);
            end
            tick();
            idx++;
        end
        drain_ready = 1'b0;
        n_checks++;
        if (drain_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_redrain_done: got %b expected 1", drain_done);
        end
        tick();
        m_lock = 0;
    endtask

    task automatic test_random();
        logic [ROWS*DATA_W-1:0] exp_p;
        int idx;
        bit finished;
        bit accepted;
        logic [TILE_W-1:0] dt;
        for (int n = 0; n < 60; n++) begin
            rand_writes();
            tick();
            idle_inputs();
            for (int t = 0; t < TILES; t++) begin
                acc_tile_index = TILE_W'(t);
                #1;
                for (int r = 0; r < ROWS; r++) exp_p[r*DATA_W +: DATA_W] = model[t][r];
                n_checks++;
                if (M_out !== exp_p) begin
                    n_fail++;
                    $display("FAIL rand_write_n%0d_t%0d: got %h expected %h", n, t, M_out, exp_p);
                end
            end
            n_checks++;
            if (wr_conflict !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_write_conflict_n%0d: got %b expected 0", n, wr_conflict);
            end
        end
        for (int d = 0; d < 6; d++) begin
            dt = TILE_W'($urandom_range(0, TILES - 1));
            rand_writes();
            drain_start = 1'b1; drain_tile_index = dt;
            tick();
            drain_start = 1'b0;
            m_lock = 1; m_lock_tile = dt;
            idx = 0;
            finished = 0;
            for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
                n_checks++;
                if (idx < ROWS) begin
                    if (drain_valid !== 1'b1 || drain_done !== 1'b0 || drain_row !== IDX_W'(idx) ||
                        drain_data !== model[dt][idx]) begin
                        n_fail++;
                        $display("FAIL rand_drain%0d_beat: got v=%b d=%b row=%0d data=%h expected 1/0 row=%0d data=%h",
                                 d, drain_valid, drain_done, drain_row, drain_data, idx, model[dt][idx]);
                    end
                end else begin
                    if ({drain_done, drain_valid, drain_busy} !== 3'b101) begin
                        n_fail++;
                        $display("FAIL rand_drain%0d_done: got d/v/b=%b expected 101",
                                 d, {drain_done, drain_valid, drain_busy});
                    end
                    finished = 1;
                end
                n_checks++;
                if (wr_conflict !== exp_conflict) begin
                    n_fail++;
                    $display("FAIL rand_drain%0d_conflict: got %b expected %b", d, wr_conflict, exp_conflict);
                end
                rand_writes();
                drain_ready = $urandom_range(0, 1);
                accepted = (idx < ROWS) && drain_ready;
                tick();
                if (accepted) idx++;
            end
            idle_inputs();
            m_lock = 0;
            n_checks++;
            if (!finished || drain_busy !== 1'b0 || wr_conflict !== exp_conflict) begin
                n_fail++;
                $display("FAIL rand_drain%0d_end: got finished=%b busy=%b conflict=%b expected 1/0/%b",
                         d, finished, drain_busy, wr_conflict, exp_conflict);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_row_write();
        test_priority();
        test_drain();
        test_lock();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
